iq_issue: RTL and testbench

//   Read end of the issue queue: examines the two oldest IQ entries each cycle and pops 0, 1 or 2 of them.

---
 rtl/iq_issue_pkg.sv | 6 +
 rtl/iq_scoreboard.sv | 47 ++++
 rtl/iq_issue.sv | 120 ++++++++++++
 tb/tb_iq_issue.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_issue_pkg.sv
// iq_issue_pkg: shared widths for the issue-queue read end
package iq_issue_pkg;
    localparam int WIDTH_UOP = 16;
    localparam int REG_W     = 5;
    localparam int NREG_DEF  = 32;
endpackage

// File: rtl/iq_scoreboard.sv
// iq_scoreboard: busy bits for registers awaiting a long-latency writeback
//   set_en_i/set_idx*_i : mark destination busy at issue (two issue slots)
//   clr_en_i/clr_idx_i  : writeback clears the destination
//   chk*_i              : rd/rj/rk of each head entry; hazard*_o if any is busy
//   idle_o              : no register busy
module iq_scoreboard
    import iq_issue_pkg::*;
#(
    parameter int NREG = NREG_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       set_en_i,
    input  logic [REG_W-1:0] set_idx0_i,
    input  logic [REG_W-1:0] set_idx1_i,
    input  logic             clr_en_i,
    input  logic [REG_W-1:0] clr_idx_i,
    input  logic [REG_W-1:0] chk0_rd_i,
    input  logic [REG_W-1:0] chk0_rj_i,
    input  logic [REG_W-1:0] chk0_rk_i,
    input  logic [REG_W-1:0] chk1_rd_i,
    input  logic [REG_W-1:0] chk1_rj_i,
    input  logic [REG_W-1:0] chk1_rk_i,
    output logic             hazard0_o,
    output logic             hazard1_o,
    output logic             idle_o
);
    logic [NREG-1:0] busy_q, busy_d;

    // Clear before set so a same-cycle set of the same index wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
        if (set_en_i[0]) busy_d[set_idx0_i] = 1'b1;
        if (set_en_i[1]) busy_d[set_idx1_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;

    // busy_q[0] is always 0, so r0 operands never raise a hazard.
    assign hazard0_o = busy_q[chk0_rd_i] | busy_q[chk0_rj_i] | busy_q[chk0_rk_i];
    assign hazard1_o = busy_q[chk1_rd_i] | busy_q[chk1_rj_i] | busy_q[chk1_rk_i];
    assign idle_o    = ~|busy_q;
endmodule

// File: rtl/iq_issue.sv
// iq_issue: selects 0..2 oldest IQ entries for dual issue into the EX latch
//   iq_*0/1   : IQ head and head+1 entries; iq_pop reports entries consumed
//   ex_*0/1   : registered EX-stage pair, handed over when ex_ready
//   wb_*      : long-latency writeback clearing the scoreboard
//   flush     : drops the EX latch contents and blocks issue this cycle
//   perf_issued : wrapping count of issued instructions
module iq_issue
    import iq_issue_pkg::*;
#(
    parameter int UOP_W = WIDTH_UOP,
    parameter int NREG  = NREG_DEF,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             iq_valid0,
    input  logic             iq_valid1,
    input  logic [UOP_W-1:0] iq_uop0,
    input  logic [UOP_W-1:0] iq_uop1,
    input  logic [31:0]      iq_imm0,
    input  logic [31:0]      iq_imm1,
    input  logic [REG_W-1:0] iq_rd0,
    input  logic [REG_W-1:0] iq_rd1,
    input  logic [REG_W-1:0] iq_rj0,
    input  logic [REG_W-1:0] iq_rj1,
    input  logic [REG_W-1:0] iq_rk0,
    input  logic [REG_W-1:0] iq_rk1,
    input  logic             iq_alu0,
    input  logic             iq_alu1,
    input  logic             iq_serial0,
    input  logic             iq_serial1,
    output logic [1:0]       iq_pop,
    input  logic             ex_ready,
    output logic             ex_valid0,
    output logic             ex_valid1,
    output logic [UOP_W-1:0] ex_uop0,
    output logic [UOP_W-1:0] ex_uop1,
    output logic [31:0]      ex_imm0,
    output logic [31:0]      ex_imm1,
    output logic [REG_W-1:0] ex_rd0,
    output logic [REG_W-1:0] ex_rd1,
    output logic [REG_W-1:0] ex_rj0,
    output logic [REG_W-1:0] ex_rj1,
    output logic [REG_W-1:0] ex_rk0,
    output logic [REG_W-1:0] ex_rk1,
    output logic             ex_alu0,
    output logic             ex_alu1,
    output logic             ex_serial0,
    output logic             ex_serial1,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    output logic [CNT_W-1:0] perf_issued
);
    localparam int SW = UOP_W + 32 + 3 * REG_W + 2;

    logic [SW-1:0]    in0, in1, ex0_q, ex0_d, ex1_q, ex1_d;
    logic             exv0_q, exv0_d, exv1_q, exv1_d;
    logic [CNT_W-1:0] perf_q, perf_d;
    logic             h0, h1, sb_idle, adv, serial_ok, raw, s0, s1;

    assign in0 = {iq_uop0, iq_imm0, iq_rd0, iq_rj0, iq_rk0, iq_alu0, iq_serial0};
    assign in1 = {iq_uop1, iq_imm1, iq_rd1, iq_rj1, iq_rk1, iq_alu1, iq_serial1};
    assign {ex_uop0, ex_imm0, ex_rd0, ex_rj0, ex_rk0, ex_alu0, ex_serial0} = ex0_q;
    assign {ex_uop1, ex_imm1, ex_rd1, ex_rj1, ex_rk1, ex_alu1, ex_serial1} = ex1_q;
    assign ex_valid0   = exv0_q;
    assign ex_valid1   = exv1_q;
    assign perf_issued = perf_q;

    iq_scoreboard #(.NREG(NREG)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   ({s1 & ~iq_alu1, s0 & ~iq_alu0}),
        .set_idx0_i (iq_rd0),
        .set_idx1_i (iq_rd1),
        .clr_en_i   (wb_valid),
        .clr_idx_i  (wb_rd),
        .chk0_rd_i  (iq_rd0),
        .chk0_rj_i  (iq_rj0),
        .chk0_rk_i  (iq_rk0),
        .chk1_rd_i  (iq_rd1),
        .chk1_rj_i  (iq_rj1),
        .chk1_rk_i  (iq_rk1),
        .hazard0_o  (h0),
        .hazard1_o  (h1),
        .idle_o     (sb_idle)
    );

    // Serializing ops wait until nothing is in flight ahead of them.
    // Slot1 may not read or rewrite slot0's destination, and at most one
    // long-latency op issues per cycle.
    always_comb begin
        adv       = ~exv0_q | ex_ready;
        serial_ok = ~iq_serial0 | (sb_idle & ~exv0_q);
        s0        = ~rst & adv & iq_valid0 & ~h0 & ~flush & serial_ok;
        raw       = (iq_rd0 != '0) & (iq_rj1 == iq_rd0 | iq_rk1 == iq_rd0 | iq_rd1 == iq_rd0);
        s1        = s0 & iq_valid1 & ~h1 & ~iq_serial0 & ~iq_serial1 & ~raw & (iq_alu0 | iq_alu1);
        iq_pop    = {s1, s0 & ~s1};
        exv0_d    = flush ? 1'b0 : adv ? s0 : exv0_q;
        exv1_d    = flush ? 1'b0 : adv ? s1 : exv1_q;
        ex0_d     = s0 ? in0 : ex0_q;
        ex1_d     = s1 ? in1 : ex1_q;
        perf_d    = perf_q + CNT_W'(iq_pop);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            exv0_q <= 1'b0;
            exv1_q <= 1'b0;
            ex0_q  <= '0;
            ex1_q  <= '0;
            perf_q <= '0;
        end else begin
            exv0_q <= exv0_d;
            exv1_q <= exv1_d;
            ex0_q  <= ex0_d;
            ex1_q  <= ex1_d;
            perf_q <= perf_d;
        end
endmodule

// File: tb/tb_iq_issue.sv
// tb_iq_issue: directed scenarios plus random traffic against a queue/scoreboard reference model
module tb_iq_issue;
    localparam int UW = 16;

    typedef struct packed {
        logic [UW-1:0] uop;
        logic [31:0]   imm;
        logic [4:0]    rd, rj, rk;
        logic          alu, serial;
    } ins_t;

    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, ex_ready = 1'b1, wb_valid = 1'b0;
    logic iq_valid0, iq_valid1, iq_alu0, iq_alu1, iq_serial0, iq_serial1;
    logic [UW-1:0] iq_uop0, iq_uop1, ex_uop0, ex_uop1;
    logic [31:0] iq_imm0, iq_imm1, ex_imm0, ex_imm1, perf_issued;
    logic [4:0] iq_rd0, iq_rd1, iq_rj0, iq_rj1, iq_rk0, iq_rk1, wb_rd = 5'd0;
    logic [4:0] ex_rd0, ex_rd1, ex_rj0, ex_rj1, ex_rk0, ex_rk1;
    logic [1:0] iq_pop;
    logic ex_valid0, ex_valid1, ex_alu0, ex_alu1, ex_serial0, ex_serial1;

    iq_issue #(.UOP_W(UW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .iq_valid0(iq_valid0), .iq_valid1(iq_valid1),
        .iq_uop0(iq_uop0), .iq_uop1(iq_uop1), .iq_imm0(iq_imm0), .iq_imm1(iq_imm1),
        .iq_rd0(iq_rd0), .iq_rd1(iq_rd1), .iq_rj0(iq_rj0), .iq_rj1(iq_rj1),
        .iq_rk0(iq_rk0), .iq_rk1(iq_rk1), .iq_alu0(iq_alu0), .iq_alu1(iq_alu1),
        .iq_serial0(iq_serial0), .iq_serial1(iq_serial1), .iq_pop(iq_pop),
        .ex_ready(ex_ready), .ex_valid0(ex_valid0), .ex_valid1(ex_valid1),
        .ex_uop0(ex_uop0), .ex_uop1(ex_uop1), .ex_imm0(ex_imm0), .ex_imm1(ex_imm1),
        .ex_rd0(ex_rd0), .ex_rd1(ex_rd1), .ex_rj0(ex_rj0), .ex_rj1(ex_rj1),
        .ex_rk0(ex_rk0), .ex_rk1(ex_rk1), .ex_alu0(ex_alu0), .ex_alu1(ex_alu1),
        .ex_serial0(ex_serial0), .ex_serial1(ex_serial1),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .perf_issued(perf_issued)
    );

    always #5 clk = ~clk;

    ins_t       q[$];
    bit  [31:0] busy;
    bit         mv0, mv1;
    ins_t       ms0, ms1;
    logic [31:0] mperf;
    int avail = 2, last_pop, n_chk = 0, n_fail = 0;
    logic [UW-1:0] held_uop;

    task automatic chk(string tag, logic [95:0] obs, logic [95:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ins_t mk(int rd, int rj, int rk, bit alu, bit serial);
        ins_t x;
        x.uop = UW'($urandom); x.imm = $urandom;
        x.rd = 5'(rd); x.rj = 5'(rj); x.rk = 5'(rk); x.alu = alu; x.serial = serial;
        return x;
    endfunction

    function automatic bit haz(ins_t x);
        return (x.rd != 0 && busy[x.rd]) || (x.rj != 0 && busy[x.rj]) || (x.rk != 0 && busy[x.rk]);
    endfunction

    // How many entries may leave the IQ this cycle, from the pairing rules.
    function automatic int exp_pop();
        ins_t a, b;
        bit v0, v1, can0, can1;
        v0 = avail >= 1 && q.size() >= 1;
        v1 = avail >= 2 && q.size() >= 2;
        if (!v0) return 0;
        a = q[0];
        can0 = (!mv0 || ex_ready) && !flush && !haz(a) && (!a.serial || (busy == 0 && !mv0));
        if (!can0) return 0;
        if (!v1) return 1;
        b = q[1];
        can1 = !haz(b) && !a.serial && !b.serial && (a.alu || b.alu) &&
               !(a.rd != 0 && (b.rj == a.rd || b.rk == a.rd || b.rd == a.rd));
        return can1 ? 2 : 1;
    endfunction

    task automatic drive();
        ins_t a, b;
        a = q.size() > 0 ? q[0] : '0;
        b = q.size() > 1 ? q[1] : '0;
        iq_valid0 = avail >= 1 && q.size() >= 1;
        iq_valid1 = avail >= 2 && q.size() >= 2;
        {iq_uop0, iq_imm0, iq_rd0, iq_rj0, iq_rk0, iq_alu0, iq_serial0} = a;
        {iq_uop1, iq_imm1, iq_rd1, iq_rj1, iq_rk1, iq_alu1, iq_serial1} = b;
    endtask

    task automatic model_reset();
        busy = 0; mv0 = 0; mv1 = 0; ms0 = '0; ms1 = '0; mperf = 0;
    endtask

    task automatic check_out();
        chk("ex_valid0", ex_valid0, mv0);
        chk("ex_valid1", ex_valid1, mv1);
        chk("perf_issued", perf_issued, mperf);
        if (mv0) chk("ex_slot0", {ex_uop0, ex_imm0, ex_rd0, ex_rj0, ex_rk0, ex_alu0, ex_serial0}, ms0);
        if (mv1) chk("ex_slot1", {ex_uop1, ex_imm1, ex_rd1, ex_rj1, ex_rk1, ex_alu1, ex_serial1}, ms1);
    endtask

    // One clock: inputs driven just after an edge, pop checked mid-cycle,
    // registered outputs checked just after the next edge.
    task automatic step();
        int p;
        bit adv;
        drive();
        #2;
        p = exp_pop();
        chk("iq_pop", iq_pop, p);
        @(posedge clk);
        #1;
        adv = !mv0 || ex_ready;
        if (wb_valid) busy[wb_rd] = 0;
        for (int i = 0; i < p; i++) if (!q[i].alu && q[i].rd != 0) busy[q[i].rd] = 1;
        busy[0] = 0;
        if (flush) begin
            mv0 = 0; mv1 = 0;
        end else if (adv) begin
            mv0 = p >= 1; mv1 = p >= 2;
            if (p >= 1) ms0 = q[0];
            if (p >= 2) ms1 = q[1];
        end
        for (int i = 0; i < p; i++) void'(q.pop_front());
        mperf += 32'(p);
        check_out();
        last_pop = p;
    endtask

    initial begin
        model_reset();
        q.push_back(mk(1, 2, 3, 1, 0));
        q.push_back(mk(4, 5, 6, 1, 0));
        drive();
        #12;
        chk("rst_pop", iq_pop, 0);
        chk("rst_ex_valid0", ex_valid0, 0);
        chk("rst_ex_valid1", ex_valid1, 0);
        chk("rst_ex_payload", {ex_uop0, ex_imm0, ex_uop1, ex_imm1}, 0);
        chk("rst_perf", perf_issued, 0);
        @(posedge clk); #1;
        rst = 0;
        q.delete();

        // independent ALU pair
        q.push_back(mk(1, 2, 3, 1, 0));
        q.push_back(mk(4, 5, 6, 1, 0));
        step();
        chk("alu_pair_pop", last_pop, 2);
        chk("alu_pair_v1", ex_valid1, 1);
        chk("alu_pair_perf", perf_issued, 2);

        // RAW pair splits over two cycles
        q.push_back(mk(1, 4, 5, 1, 0));
        q.push_back(mk(2, 1, 3, 1, 0));
        step();
        chk("raw_first", last_pop, 1);
        step();
        chk("raw_second", last_pop, 1);

        // load r7 then consumer of r7
        q.push_back(mk(7, 1, 2, 0, 0));
        q.push_back(mk(8, 7, 3, 1, 0));
        step();
        chk("load_issue", last_pop, 1);
        step();
        chk("use_stall_a", last_pop, 0);
        step();
        chk("use_stall_b", last_pop, 0);
        wb_valid = 1; wb_rd = 7;
        step();
        chk("use_stall_wb", last_pop, 0);
        wb_valid = 0;
        step();
        chk("use_after_wb", last_pop, 1);

        // serializing op waits for r9 and an empty latch
        q.push_back(mk(9, 1, 2, 0, 0));
        q.push_back(mk(0, 0, 0, 1, 1));
        step();
        chk("pre_serial", last_pop, 1);
        step();
        chk("serial_wait_a", last_pop, 0);
        step();
        chk("serial_wait_b", last_pop, 0);
        wb_valid = 1; wb_rd = 9;
        step();
        chk("serial_wait_wb", last_pop, 0);
        wb_valid = 0;
        step();
        chk("serial_issue", last_pop, 1);
        chk("serial_alone", ex_valid1, 0);

        // EX back-pressure holds the latch
        q.push_back(mk(10, 1, 2, 1, 0));
        q.push_back(mk(11, 1, 2, 1, 0));
        avail = 1;
        step();
        held_uop = ex_uop0;
        ex_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pop", last_pop, 0);
            chk("stall_hold", ex_uop0, held_uop);
        end
        ex_ready = 1;
        step();
        chk("stall_resume", last_pop, 1);
        avail = 2;
        q.delete();

        // flush with two valid entries
        q.push_back(mk(12, 1, 2, 1, 0));
        q.push_back(mk(13, 3, 4, 1, 0));
        flush = 1;
        step();
        chk("flush_pop", last_pop, 0);
        chk("flush_v0", ex_valid0, 0);
        flush = 0;
        q.delete();

        // async reset while stalled with a busy register
        q.push_back(mk(14, 1, 2, 0, 0));
        step();
        ex_ready = 0;
        q.push_back(mk(15, 1, 2, 1, 0));
        step();
        rst = 1;
        #1;
        chk("midrst_v0", ex_valid0, 0);
        chk("midrst_uop", ex_uop0, 0);
        chk("midrst_perf", perf_issued, 0);
        chk("midrst_pop", iq_pop, 0);
        @(posedge clk); #1;
        rst = 0;
        ex_ready = 1;
        model_reset();
        q.delete();
        q.push_back(mk(1, 14, 0, 1, 0));
        step();
        chk("sb_cleared", last_pop, 1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            while (q.size() < 4)
                q.push_back(mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                               ($urandom % 3) != 0, ($urandom % 16) == 0));
            avail    = ($urandom % 4 == 0) ? $urandom_range(0, 1) : 2;
            flush    = ($urandom % 20) == 0;
            ex_ready = ($urandom % 4) != 0;
            wb_valid = ($urandom % 3) == 0;
            wb_rd    = 5'($urandom_range(0, 7));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
